bus_run_ctrl: RTL and testbench
===============================

BUS_RUN_CTRL -- requirements
Module: bus_run_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, bus data width in bits.
REQ-002 Parameter N_SRC, default 6, number of bus driver sources.
REQ-003 Parameter CNT_W, default 8, contention counter width.
REQ-004 i_clk  input  1  system clock; all state changes on rising edge.
REQ-005 i_reset  input  1  synchronous, active-high.
REQ-006 i_srcData  input  N_SRC*WIDTH  source k data at bits [k*WIDTH +: WIDTH].
REQ-007 i_srcNoe  input  N_SRC  active-low output enable per source; bit k enables source k.
REQ-008 i_hlt  input  1  halt request from control unit, level.
REQ-009 i_button  input  1  run/step button, level, already synchronised to i_clk.
REQ-010 i_stepMode  input  1  1 = button single-steps; 0 = button resumes free run.
REQ-011 o_bus  output  WIDTH  resolved bus value.
REQ-012 o_busValid  output  1  at least one source enabled this cycle.
REQ-013 o_clkEn  output  1  clock enable for all datapath state.
REQ-014 o_halted  output  1  run FSM in HALTED.
REQ-015 o_contention  output  1  sticky flag, two or more sources enabled during an enabled cycle.
REQ-016 o_contentionCnt  output  CNT_W  saturating count of contention cycles.
REQ-017 o_contentionSrc  output  N_SRC  active-high enable mask captured at the most recent contention.

Function
REQ-018 o_bus SHALL be combinational: data of the lowest-index source with i_srcNoe[k]=0.
REQ-019 With no source enabled, o_bus SHALL equal the keeper register and o_busValid SHALL be 0.
REQ-020 Keeper SHALL load the resolved o_bus on every clock with o_busValid=1, independent of o_clkEn.
REQ-021 Contention cycle = o_clkEn=1 and two or more i_srcNoe bits 0; on each such edge: o_contention set, o_contentionCnt +1, o_contentionSrc loaded with ~i_srcNoe.
REQ-022 o_contentionCnt SHALL saturate at 2^CNT_W-1; no wrap.
REQ-023 Contention with o_clkEn=0 SHALL not update any contention output.
REQ-024 Run FSM states: RUN, HALTED, STEP.
REQ-025 o_clkEn = (RUN and not i_hlt) or STEP; combinational, so the halt request cycle itself is not clocked.
REQ-026 RUN: i_hlt=1 -> HALTED next cycle; button edges ignored.
REQ-027 HALTED: o_clkEn=0; i_button rising edge (i_button=1, previous sample 0) with i_stepMode=0 -> RUN, with i_stepMode=1 -> STEP.
REQ-028 STEP: o_clkEn=1 for exactly one cycle, then HALTED unconditionally, regardless of i_hlt or i_button.
REQ-029 Button held high SHALL produce one edge only; re-arm requires i_button=0 for at least one cycle.
REQ-030 i_hlt ignored outside RUN; HALTED exits only on button edge or reset.
REQ-031 o_halted SHALL be registered state decode, 1 only in HALTED.

Reset
REQ-032 i_reset=1 on a clock edge SHALL force: FSM RUN, keeper 0, button-previous sample 0, o_contention 0, o_contentionCnt 0, o_contentionSrc 0.
REQ-033 Reset SHALL take priority over i_hlt, button edge and contention in the same cycle, including reset from STEP or HALTED.
REQ-034 During reset cycle o_clkEn follows REQ-025 from pre-reset state; after release o_clkEn=1 unless i_hlt=1.

Verification
REQ-035 Resolve: WIDTH=8, N_SRC=6; src2=0x5A, src4=0x33, noe=6'b101011 -> o_bus=0x5A, o_busValid=1, contention set, cnt=1, mask=6'b010100.
REQ-036 Keeper: drive src0=0xC3 one cycle, then noe=6'b111111 -> o_bus stays 0xC3, o_busValid=0, for 10 cycles.
REQ-037 Halt/step: RUN, i_hlt=1 -> o_clkEn=0 same cycle, o_halted=1 next; stepMode=1, button pulse 1 cycle -> exactly one o_clkEn=1 cycle, back to HALTED; held button 5 cycles -> still one step.
REQ-038 Resume: HALTED, stepMode=0, button edge -> RUN, o_clkEn=1 continuously while i_hlt=0.
REQ-039 Saturation: CNT_W=2, 6 contention cycles -> cnt 1,2,3,3,3,3; contention while HALTED -> no change.
REQ-040 Reset mid-operation: in STEP with cnt=3 and keeper=0xC3, i_reset=1 -> next cycle RUN, cnt=0, keeper=0x00, o_contention=0, o_halted=0.

Source files
------------

// File: rtl/bus_run_ctrl.sv
// Shared-bus resolver with keeper and contention monitor, plus the run/halt/step
// controller that produces the global datapath clock enable.
module bus_run_ctrl #(
   parameter int WIDTH = 8,
   parameter int N_SRC = 6,
   parameter int CNT_W = 8
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic [N_SRC*WIDTH-1:0] i_srcData,
   input  logic [N_SRC-1:0]       i_srcNoe,
   input  logic                   i_hlt,
   input  logic                   i_button,
   input  logic                   i_stepMode,
   output logic [WIDTH-1:0]       o_bus,
   output logic                   o_busValid,
   output logic                   o_clkEn,
   output logic                   o_halted,
   output logic                   o_contention,
   output logic [CNT_W-1:0]       o_contentionCnt,
   output logic [N_SRC-1:0]       o_contentionSrc
);

   typedef enum logic [1:0] {RUN, HALTED, STEP} state_t;

   state_t             state_q;
   logic               halted_q;
   logic               btn_prev_q;
   logic [WIDTH-1:0]   keeper_q;
   logic               contention_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   cnt_d;
   logic [N_SRC-1:0]   src_q;

   logic [WIDTH-1:0]   bus_sel;
   logic               any_en;
   logic               multi_en;
   logic               clk_en;
   logic               btn_edge;

   // Lowest-index enabled source wins; the keeper holds the last driven value.
   always_comb begin
      bus_sel  = keeper_q;
      any_en   = 1'b0;
      multi_en = 1'b0;
      for (int k = 0; k < N_SRC; k++) begin
         if (!i_srcNoe[k]) begin
            if (any_en) begin
               multi_en = 1'b1;
            end else begin
               bus_sel = i_srcData[k*WIDTH +: WIDTH];
            end
            any_en = 1'b1;
         end
      end
   end

   // Combinational so the cycle that raises i_hlt is already not clocked.
   assign clk_en   = ((state_q == RUN) && !i_hlt) || (state_q == STEP);
   assign btn_edge = i_button && !btn_prev_q;
   assign cnt_d    = (&cnt_q) ? cnt_q : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q    <= RUN;
         halted_q   <= 1'b0;
         btn_prev_q <= 1'b0;
      end else begin
         btn_prev_q <= i_button;
         case (state_q)
            RUN: begin
               if (i_hlt) begin
                  state_q  <= HALTED;
                  halted_q <= 1'b1;
               end
            end
            HALTED: begin
               if (btn_edge) begin
                  state_q  <= i_stepMode ? STEP : RUN;
                  halted_q <= 1'b0;
               end
            end
            STEP: begin
               state_q  <= HALTED;
               halted_q <= 1'b1;
            end
            default: begin
               state_q  <= RUN;
               halted_q <= 1'b0;
            end
         endcase
      end
   end

   // Keeper tracks the bus whenever driven, even while the datapath is stalled.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         keeper_q     <= '0;
         contention_q <= 1'b0;
         cnt_q        <= '0;
         src_q        <= '0;
      end else begin
         if (any_en) begin
            keeper_q <= bus_sel;
         end
         if (clk_en && multi_en) begin
            contention_q <= 1'b1;
            cnt_q        <= cnt_d;
            src_q        <= ~i_srcNoe;
         end
      end
   end

   assign o_bus           = bus_sel;
   assign o_busValid      = any_en;
   assign o_clkEn         = clk_en;
   assign o_halted        = halted_q;
   assign o_contention    = contention_q;
   assign o_contentionCnt = cnt_q;
   assign o_contentionSrc = src_q;

endmodule

// File: tb/tb_bus_run_ctrl.sv
// Scoreboard bench for bus_run_ctrl: directed stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares them.
module tb_bus_run_ctrl;

   localparam int WIDTH = 8;
   localparam int N_SRC = 6;
   localparam int CNT_W = 2;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [N_SRC*WIDTH-1:0] src_data;
   logic [N_SRC-1:0]       noe;
   logic                   hlt, btn, smode;
   logic [WIDTH-1:0]       bus;
   logic                   bus_valid, clk_en, halted, contention;
   logic [CNT_W-1:0]       cnt;
   logic [N_SRC-1:0]       csrc;

   typedef struct {
      string      name;
      logic [7:0] bus;
      logic       bv;
      logic       ce;
      logic       hl;
      logic       ct;
      logic [1:0] cnt;
      logic [5:0] src;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   logic [7:0] e_bus;
   logic       e_bv, e_ce, e_hl, e_ct;
   logic [1:0] e_cnt;
   logic [5:0] e_src;

   bus_run_ctrl #(.WIDTH(WIDTH), .N_SRC(N_SRC), .CNT_W(CNT_W)) dut (
      .i_clk           (clk),
      .i_reset         (rst),
      .i_srcData       (src_data),
      .i_srcNoe        (noe),
      .i_hlt           (hlt),
      .i_button        (btn),
      .i_stepMode      (smode),
      .o_bus           (bus),
      .o_busValid      (bus_valid),
      .o_clkEn         (clk_en),
      .o_halted        (halted),
      .o_contention    (contention),
      .o_contentionCnt (cnt),
      .o_contentionSrc (csrc)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_src(input int k, input logic [7:0] v);
      src_data[k*WIDTH +: WIDTH] = v;
   endtask

   task automatic chk(input string name);
      exp_t e;
      e.name = name; e.bus = e_bus; e.bv = e_bv; e.ce = e_ce; e.hl = e_hl;
      e.ct = e_ct; e.cnt = e_cnt; e.src = e_src;
      q.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            n_checks++;
            if ({bus, bus_valid, clk_en, halted, contention, cnt, csrc} !==
                {e.bus, e.bv, e.ce, e.hl, e.ct, e.cnt, e.src}) begin
               n_errors++;
               $display("FAIL %s: got bus=%h bv=%b ce=%b hl=%b ct=%b cnt=%0d src=%b, want bus=%h bv=%b ce=%b hl=%b ct=%b cnt=%0d src=%b",
                        e.name, bus, bus_valid, clk_en, halted, contention, cnt, csrc,
                        e.bus, e.bv, e.ce, e.hl, e.ct, e.cnt, e.src);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      logic [1:0] cnt_tab [5];
      cnt_tab = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

      rst = 1'b1; src_data = '0; noe = 6'b111111; hlt = 1'b0; btn = 1'b0; smode = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
      e_bus = 8'h00; e_bv = 0; e_ce = 1; e_hl = 0; e_ct = 0; e_cnt = 0; e_src = 6'b000000;
      chk("reset_state");

      // Resolve with two drivers: src2 wins, contention captured at the edge.
      tick();
      set_src(2, 8'h5A); set_src(4, 8'h33); noe = 6'b101011;
      e_bus = 8'h5A; e_bv = 1;
      chk("resolve");
      tick();
      noe = 6'b111111;
      e_bv = 0; e_ct = 1; e_cnt = 1; e_src = 6'b010100;
      chk("contend_capture");

      // Keeper holds src0 value once the bus is released.
      tick();
      set_src(0, 8'hC3); noe = 6'b111110;
      e_bus = 8'hC3; e_bv = 1;
      chk("keeper_load");
      tick();
      noe = 6'b111111; e_bv = 0;
      chk("keeper_release");
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("keeper_hold");
      end

      // Five more contention cycles: count saturates at 3.
      set_src(1, 8'h11);
      for (int i = 0; i < 5; i++) begin
         tick();
         noe = 6'b111100;
         e_bus = 8'hC3; e_bv = 1; e_cnt = cnt_tab[i];
         e_src = (i == 0) ? 6'b010100 : 6'b000011;
         chk("saturate");
      end
      tick();
      noe = 6'b111111;
      e_bv = 0; e_cnt = 3; e_src = 6'b000011;
      chk("saturate_final");

      // Halt request: clock enable drops in the same cycle.
      tick();
      hlt = 1'b1; e_ce = 0; e_hl = 0;
      chk("halt_req");
      tick();
      hlt = 1'b0; e_hl = 1;
      chk("halted");
      tick();
      noe = 6'b110011; e_bus = 8'h5A; e_bv = 1;
      chk("halt_contend");
      tick();
      noe = 6'b111111; e_bv = 0;
      chk("halt_no_update");

      // Single step from a one-cycle button pulse, with contention in the step cycle.
      smode = 1'b1;
      tick();
      btn = 1'b1;
      chk("step_press");
      tick();
      btn = 1'b0; noe = 6'b110011; e_ce = 1; e_hl = 0; e_bv = 1;
      chk("step_cycle");
      tick();
      noe = 6'b111111; e_ce = 0; e_hl = 1; e_bv = 0; e_src = 6'b001100;
      chk("step_done");
      tick();
      chk("step_stay");

      // Button held for five cycles gives exactly one step.
      tick();
      btn = 1'b1;
      chk("held_press");
      tick();
      e_ce = 1; e_hl = 0;
      chk("held_step");
      tick();
      e_ce = 0; e_hl = 1;
      chk("held_1");
      tick();
      chk("held_2");
      tick();
      chk("held_3");
      tick();
      btn = 1'b0;
      chk("held_release");
      tick();
      chk("held_stay");

      // Resume free run.
      smode = 1'b0;
      tick();
      btn = 1'b1;
      chk("resume_press");
      tick();
      btn = 1'b0; e_ce = 1; e_hl = 0;
      chk("resume_run");
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("run_free");
      end

      // Reset while in STEP with keeper=C3 and cnt=3; hlt asserted alongside.
      tick();
      hlt = 1'b1; noe = 6'b111110; e_bus = 8'hC3; e_bv = 1; e_ce = 0;
      chk("halt2_req");
      tick();
      hlt = 1'b0; noe = 6'b111111; e_bv = 0; e_hl = 1;
      chk("halt2");
      smode = 1'b1;
      tick();
      btn = 1'b1;
      chk("step2_press");
      tick();
      btn = 1'b0; rst = 1'b1; hlt = 1'b1; e_ce = 1; e_hl = 0;
      chk("reset_in_step");
      tick();
      rst = 1'b0; hlt = 1'b0;
      e_bus = 8'h00; e_bv = 0; e_ce = 1; e_hl = 0; e_ct = 0; e_cnt = 0; e_src = 6'b000000;
      chk("reset_release");
      tick();
      hlt = 1'b1; e_ce = 0;
      chk("post_reset_hlt");
      tick();
      hlt = 1'b0; e_hl = 1;
      chk("post_reset_halted");

      tick();
      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      #1;
      if (q.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL drain: %0d expectations left, want 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
